// File: rtl/pipe_pkg.sv
// Shared types and helpers for the scrolling pipe field scheduler.
package pipe_pkg;

    localparam int unsigned FIELD_W = 16;
    localparam int unsigned FIELD_H = 16;
    localparam int unsigned GAP_H = 4;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {IDLE, RUN, OVER} game_state_t;

    typedef logic [FIELD_H-1:0] column_t;

    // Gap top row in 1..11 so a 4-row gap never reaches rows 0 or 15.
    function automatic logic [3:0] gap_from_lfsr(logic [15:0] v);
        logic [3:0] n;
        n = v[3:0];
        return (n % 4'd11) + 4'd1;
    endfunction

    function automatic column_t pipe_pattern(logic [3:0] gap);
        column_t ones;
        ones = (column_t'(1) << GAP_H) - column_t'(1);
        return ~(ones << gap);
    endfunction

endpackage

// File: rtl/pipe_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) with enable and reset seed.
module pipe_lfsr
    import pipe_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/pipe_scheduler.sv
// Game-phase FSM, scroll/spawn timing, scoring and speed ramp for the pipe field.
module pipe_scheduler
    import pipe_pkg::*;
#(
    parameter int unsigned SCROLL_PERIOD_INIT = 12500000,
    parameter int unsigned SCROLL_PERIOD_MIN  = 3125000,
    parameter int unsigned SPEEDUP_STEP       = 625000,
    parameter int unsigned PIPE_SPACING       = 6,
    parameter int unsigned BIRD_COL           = 13
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               gameover,
    output logic               shift_en,
    output logic               spawn_en,
    output logic [FIELD_H-1:0] new_col,
    output logic               field_clr,
    output logic [7:0]         score,
    output logic               running
);

    localparam int unsigned CNT_W = $clog2(SCROLL_PERIOD_INIT + 1);
    localparam int unsigned COL_W = $clog2(PIPE_SPACING + 1);
    localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(SCROLL_PERIOD_INIT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(PIPE_SPACING - 1);

    game_state_t         state_q, state_d;
    logic [CNT_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [CNT_W-1:0]    period_q, period_d;
    logic [COL_W-1:0]    col_cnt_q, col_cnt_d;
    // Only the columns up to the bird matter for scoring.
    logic [BIRD_COL-1:0] occ_q, occ_d;
    logic [3:0]          gap_pos_q, gap_pos_d;
    logic [7:0]          score_q, score_d;
    logic                shift_en_q, shift_en_d;
    logic                spawn_en_q, spawn_en_d;
    logic                field_clr_q, field_clr_d;
    logic [15:0]         lfsr;

    pipe_lfsr u_lfsr (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (1'b1),
        .lfsr_o (lfsr)
    );

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        period_d    = period_q;
        col_cnt_d   = col_cnt_q;
        occ_d       = occ_q;
        gap_pos_d   = gap_pos_q;
        score_d     = score_q;
        shift_en_d  = 1'b0;
        spawn_en_d  = 1'b0;
        field_clr_d = 1'b0;

        // Bookkeeping for the shift currently visible on shift_en.
        if (shift_en_q) begin
            occ_d = {occ_q[BIRD_COL-2:0], spawn_en_q};
            if (occ_q[BIRD_COL-1] && (score_q != 8'hFF)) begin
                score_d = score_q + 8'd1;
                if (score_d[2:0] == 3'd0) begin
                    period_d = (32'(period_q) >= SPEEDUP_STEP + SCROLL_PERIOD_MIN)
                             ? period_q - CNT_W'(SPEEDUP_STEP)
                             : CNT_W'(SCROLL_PERIOD_MIN);
                end
            end
        end
        if (spawn_en_q) begin
            gap_pos_d = gap_from_lfsr(lfsr);
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    tick_cnt_d = '0;
                    gap_pos_d  = gap_from_lfsr(lfsr);
                end
            end
            RUN: begin
                if (gameover) begin
                    state_d = OVER;
                end else if (tick_cnt_q == period_q - CNT_W'(1)) begin
                    tick_cnt_d = '0;
                    shift_en_d = 1'b1;
                    if (col_cnt_q == COL_LAST) begin
                        spawn_en_d = 1'b1;
                        col_cnt_d  = '0;
                    end else begin
                        col_cnt_d = col_cnt_q + COL_W'(1);
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + CNT_W'(1);
                end
            end
            OVER: begin
                if (start) begin
                    state_d     = IDLE;
                    field_clr_d = 1'b1;
                    score_d     = '0;
                    occ_d       = '0;
                    period_d    = PERIOD_INIT;
                    tick_cnt_d  = '0;
                    col_cnt_d   = COL_LAST;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            period_q    <= PERIOD_INIT;
            col_cnt_q   <= COL_LAST;
            occ_q       <= '0;
            gap_pos_q   <= 4'd1;
            score_q     <= '0;
            shift_en_q  <= 1'b0;
            spawn_en_q  <= 1'b0;
            field_clr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            period_q    <= period_d;
            col_cnt_q   <= col_cnt_d;
            occ_q       <= occ_d;
            gap_pos_q   <= gap_pos_d;
            score_q     <= score_d;
            shift_en_q  <= shift_en_d;
            spawn_en_q  <= spawn_en_d;
            field_clr_q <= field_clr_d;
        end
    end

    assign shift_en  = shift_en_q;
    assign spawn_en  = spawn_en_q;
    assign field_clr = field_clr_q;
    assign score     = score_q;
    assign running   = (state_q == RUN);
    assign new_col   = spawn_en_q ? pipe_pattern(gap_pos_q) : '0;

endmodule
